// File: rtl/regsfile_sb.sv
// regsfile_sb: parametrised two-write/two-read register file with a per-register busy scoreboard.
// Define RF_WRITE_BYPASS_EN to forward same-cycle write data (and clear busy) on reads.
module regsfile_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush_i,
  input  logic                   we0_i,
  input  logic [ADDR_W-1:0]      waddr0_i,
  input  logic [DATA_W-1:0]      wdata0_i,
  input  logic                   we1_i,
  input  logic [ADDR_W-1:0]      waddr1_i,
  input  logic [DATA_W-1:0]      wdata1_i,
  input  logic                   issue_i,
  input  logic [ADDR_W-1:0]      issue_rd_i,
  input  logic                   re1_i,
  input  logic [ADDR_W-1:0]      raddr1_i,
  output logic [DATA_W-1:0]      rdata1_o,
  output logic                   busy1_o,
  input  logic                   re2_i,
  input  logic [ADDR_W-1:0]      raddr2_i,
  output logic [DATA_W-1:0]      rdata2_o,
  output logic                   busy2_o,
  output logic [2**ADDR_W-1:0]   busy_vec_o
);
  localparam int NREGS = 2**ADDR_W;
  logic [DATA_W-1:0] regs [NREGS];
  logic [NREGS-1:0]  busy, busy_next;
  logic              wz0, wz1;
  logic [1:0]        re, rb;
  logic [ADDR_W-1:0] ra [2];
  logic [DATA_W-1:0] rd [2];
  assign wz0 = ZERO_REG != 0 && waddr0_i == '0;
  assign wz1 = ZERO_REG != 0 && waddr1_i == '0;
  // Port 0 is applied last so it wins a same-address collision.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      busy <= '0;
    end else begin
      if (we1_i && !wz1) regs[waddr1_i] <= wdata1_i;
      if (we0_i && !wz0) regs[waddr0_i] <= wdata0_i;
      busy <= busy_next;
    end
  // Issue beats write-back: the issuing instruction is the younger producer.
  always_comb begin
    busy_next = busy;
    for (int i = 0; i < NREGS; i++)
      busy_next[i] = flush_i ? 1'b0
                   : (issue_i && issue_rd_i == ADDR_W'(i) && !(ZERO_REG != 0 && i == 0)) ? 1'b1
                   : ((we0_i && waddr0_i == ADDR_W'(i)) || (we1_i && waddr1_i == ADDR_W'(i))) ? 1'b0
                   : busy[i];
  end
  assign re    = {re2_i, re1_i};
  assign ra[0] = raddr1_i;
  assign ra[1] = raddr2_i;
  for (genvar p = 0; p < 2; p++) begin : g_rd
    logic zero, hit0, hit1;
    assign zero = ZERO_REG != 0 && ra[p] == '0;
`ifdef RF_WRITE_BYPASS_EN
    assign hit0 = we0_i && waddr0_i == ra[p];
    assign hit1 = we1_i && waddr1_i == ra[p];
`else
    assign hit0 = 1'b0;
    assign hit1 = 1'b0;
`endif
    assign rd[p] = (!re[p] || zero) ? '0 : hit0 ? wdata0_i : hit1 ? wdata1_i : regs[ra[p]];
    assign rb[p] = re[p] && !zero && !hit0 && !hit1 && busy[ra[p]];
  end
  assign rdata1_o   = rd[0];
  assign rdata2_o   = rd[1];
  assign busy1_o    = rb[0];
  assign busy2_o    = rb[1];
  assign busy_vec_o = busy;
endmodule

// File: tb/tb_regsfile_sb.sv
// tb_regsfile_sb: directed scoreboard bench for regsfile_sb (default 32x32, ZERO_REG=1).
module tb_regsfile_sb;
  logic        clk = 1'b0, rst_n = 1'b1, flush_i = 1'b0;
  logic        we0_i = 1'b0, we1_i = 1'b0, issue_i = 1'b0, re1_i = 1'b0, re2_i = 1'b0;
  logic [4:0]  waddr0_i = '0, waddr1_i = '0, issue_rd_i = '0, raddr1_i = '0, raddr2_i = '0;
  logic [31:0] wdata0_i = '0, wdata1_i = '0, rdata1_o, rdata2_o, busy_vec_o;
  logic        busy1_o, busy2_o;
  int          tests = 0, fails = 0;
  typedef struct { string tag; logic [31:0] val; } exp_t;
  exp_t q[$];

  regsfile_sb dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .we0_i(we0_i), .waddr0_i(waddr0_i), .wdata0_i(wdata0_i),
    .we1_i(we1_i), .waddr1_i(waddr1_i), .wdata1_i(wdata1_i),
    .issue_i(issue_i), .issue_rd_i(issue_rd_i),
    .re1_i(re1_i), .raddr1_i(raddr1_i), .rdata1_o(rdata1_o), .busy1_o(busy1_o),
    .re2_i(re2_i), .raddr2_i(raddr2_i), .rdata2_o(rdata2_o), .busy2_o(busy2_o),
    .busy_vec_o(busy_vec_o)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "timeout");
  end

  task automatic push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    q.push_back(e);
  endtask

  task automatic chk(input logic [31:0] obs);
    exp_t e;
    tests++;
    if (q.size() == 0) begin
      fails++;
      $display("FAIL scoreboard_empty: observed %h required queued expectation", obs);
    end else begin
      e = q.pop_front();
      assert (obs === e.val) else begin
        fails++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset asserted mid-cycle, released away from an edge
    @(posedge clk); #3 rst_n = 1'b0;
    @(posedge clk); #2 rst_n = 1'b1;
    tick;
    re1_i = 1'b1; re2_i = 1'b1;
    for (int a = 0; a < 32; a++) begin
      raddr1_i = 5'(a); raddr2_i = 5'(31 - a);
      push("reset_rdata1", 32'h0); push("reset_rdata2", 32'h0);
      #1; chk(rdata1_o); chk(rdata2_o);
    end
    push("reset_busy_vec", 32'h0); chk(busy_vec_o);
    // Register 0 write and issue are both ignored
    tick;
    we0_i = 1'b1; waddr0_i = 5'd0; wdata0_i = 32'hDEADBEEF;
    issue_i = 1'b1; issue_rd_i = 5'd0; raddr1_i = 5'd0;
    push("r0_rdata_same", 32'h0); push("r0_busy1_same", 32'h0);
    #1; chk(rdata1_o); chk({31'b0, busy1_o});
    tick;
    we0_i = 1'b0; issue_i = 1'b0;
    push("r0_rdata_next", 32'h0); push("r0_busy_vec0", 32'h0);
    #1; chk(rdata1_o); chk({31'b0, busy_vec_o[0]});
    // Dual-write collision on a busy register
    issue_i = 1'b1; issue_rd_i = 5'd5;
    tick;
    issue_i = 1'b0;
    push("col_busy5_set", 32'h1); #1; chk({31'b0, busy_vec_o[5]});
    we0_i = 1'b1; waddr0_i = 5'd5; wdata0_i = 32'h11111111;
    we1_i = 1'b1; waddr1_i = 5'd5; wdata1_i = 32'h22222222;
    tick;
    we0_i = 1'b0; we1_i = 1'b0; raddr1_i = 5'd5;
    push("col_reg5", 32'h11111111); push("col_busy5_clr", 32'h0);
    #1; chk(rdata1_o); chk({31'b0, busy_vec_o[5]});
    // Scoreboard set by issue, cleared by late-load write
    issue_i = 1'b1; issue_rd_i = 5'd7; raddr2_i = 5'd7;
    push("sb_busy2_issue_cycle", 32'h0); #1; chk({31'b0, busy2_o});
    tick;
    issue_i = 1'b0;
    push("sb_busy2_after_issue", 32'h1); #1; chk({31'b0, busy2_o});
    we1_i = 1'b1; waddr1_i = 5'd7; wdata1_i = 32'hA5A5A5A5;
`ifdef RF_WRITE_BYPASS_EN
    push("sb_rdata2_wb_cycle", 32'hA5A5A5A5); push("sb_busy2_wb_cycle", 32'h0);
`else
    push("sb_rdata2_wb_cycle", 32'h0); push("sb_busy2_wb_cycle", 32'h1);
`endif
    #1; chk(rdata2_o); chk({31'b0, busy2_o});
    tick;
    we1_i = 1'b0;
    push("sb_rdata2_after", 32'hA5A5A5A5); push("sb_busy2_after", 32'h0);
    #1; chk(rdata2_o); chk({31'b0, busy2_o});
    // Set beats clear, then flush clears all but keeps data
    issue_i = 1'b1; issue_rd_i = 5'd9;
    we0_i = 1'b1; waddr0_i = 5'd9; wdata0_i = 32'h00000099;
    tick;
    issue_i = 1'b0; we0_i = 1'b0; raddr1_i = 5'd9;
    push("race_busy_vec", 32'h00000200); push("race_reg9", 32'h99);
    #1; chk(busy_vec_o); chk(rdata1_o);
    issue_i = 1'b1; issue_rd_i = 5'd12; flush_i = 1'b1;
    tick;
    issue_i = 1'b0; flush_i = 1'b0;
    push("flush_busy_vec", 32'h0); push("flush_reg9", 32'h99);
    #1; chk(busy_vec_o); chk(rdata1_o);
    // Asynchronous reset mid-operation
    we0_i = 1'b1; waddr0_i = 5'd3; wdata0_i = 32'h5;
    tick;
    we0_i = 1'b0; issue_i = 1'b1; issue_rd_i = 5'd3;
    tick;
    issue_rd_i = 5'd4;
    tick;
    issue_i = 1'b0; raddr1_i = 5'd3;
    push("pre_rst_busy_vec", 32'h00000018); push("pre_rst_reg3", 32'h5);
    #1; chk(busy_vec_o); chk(rdata1_o);
    we0_i = 1'b1; waddr0_i = 5'd3; wdata0_i = 32'h77;
    #1 rst_n = 1'b0;
    push("async_rst_busy_vec", 32'h0); push("async_rst_reg3", 32'h0);
    #1; chk(busy_vec_o); chk(rdata1_o);
    @(posedge clk); #1;
    push("rst_drop_write_reg3", 32'h0); chk(rdata1_o);
    we0_i = 1'b0;
    #2 rst_n = 1'b1;
    tick;
    push("post_rst_reg3", 32'h0); #1; chk(rdata1_o);
    if (q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_leftover: observed %0d entries required 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/regsfile_sb.md
Name: regsfile_sb

Overview:
- Parametrised successor to the core integer register file.
- Adds a configurable data width and register count, plus a second write port for late load write-back.
- Adds a per-register busy scoreboard: an instruction issued with a destination marks that register pending until its write-back lands.
- Sits between id (reads, issue), wb (port 0 write) and the load unit (port 1 write); drives read-hazard stall flags to the pipeline control.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register address width; register count is NREGS = 2**ADDR_W.
- ZERO_REG, 1, 1 = register 0 is hardwired to zero (never written, never busy); 0 = register 0 is an ordinary register.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush_i  in  1  synchronous clear of all busy bits (trap/interrupt redirect); register contents are kept.
- we0_i  in  1  write enable, port 0 (wb).
- waddr0_i  in  ADDR_W  write address, port 0.
- wdata0_i  in  DATA_W  write data, port 0.
- we1_i  in  1  write enable, port 1 (late load).
- waddr1_i  in  ADDR_W  write address, port 1.
- wdata1_i  in  DATA_W  write data, port 1.
- issue_i  in  1  an instruction with a destination register issues this cycle.
- issue_rd_i  in  ADDR_W  destination register of the issuing instruction.
- re1_i  in  1  read enable, port 1.
- raddr1_i  in  ADDR_W  read address, port 1.
- rdata1_o  out  DATA_W  read data, port 1.
- busy1_o  out  1  read port 1 target is pending (consumer must stall).
- re2_i  in  1  read enable, port 2.
- raddr2_i  in  ADDR_W  read address, port 2.
- rdata2_o  out  DATA_W  read data, port 2.
- busy2_o  out  1  read port 2 target is pending.
- busy_vec_o  out  NREGS  raw scoreboard, bit i = register i pending.

Behaviour:
- Reset (asynchronous, rst_n low):
  - all registers = 0; all busy bits = 0; busy_vec_o = 0.
  - Read outputs follow their combinational rules from the cleared state.
  - Reset asserted mid-operation drops any in-flight write and all pending state immediately.
- Writes (rising clk, each port writes independently when its we is high):
  - Same address on both ports in one cycle: port 0 data is stored; port 1 is discarded.
  - If ZERO_REG = 1, writes to register 0 are ignored.
- Reads (combinational, zero latency, one rule per read port):
  - re low: rdata = 0, busy = 0.
  - re high: rdata = stored register value, subject to bypass (see Optional Feature).
  - If ZERO_REG = 1 and raddr = 0: rdata = 0 and busy = 0 regardless of writes.
- Scoreboard, per register i, next-state evaluated in this priority:
  - 1. flush_i high: busy[i] = 0, regardless of issue or write.
  - 2. issue_i high and issue_rd_i = i: busy[i] = 1. A set wins over a same-cycle clear, because the new producer is younger.
  - 3. we0_i high with waddr0_i = i, or we1_i high with waddr1_i = i: busy[i] = 0.
  - 4. otherwise: busy[i] holds.
  - If ZERO_REG = 1, issue to register 0 never sets its busy bit.
- Read busy flags:
  - busy = re & busy[raddr], then forced low if a same-cycle write to raddr is forwarded (feature on).
  - With the feature off, a same-cycle write does not clear the flag until the next cycle.
- Writes with no matching busy bit are legal and update the register normally.
- No internal counters. Issue to an already-busy register is legal: the bit stays 1 and the first write-back clears it. The pipeline must prevent WAW ordering hazards.

Optional Feature:
- Macro: RF_WRITE_BYPASS_EN.
- Defined: a read address matching an active same-cycle write address returns that write data. Port 0 is checked before port 1. The matching busy flag reads 0 that cycle.
- Undefined: reads return only the stored value, so same-cycle write data is visible from the next cycle. Busy flags come straight from the registered scoreboard. This variant suits the shorter-path timing build.

Test Plan:
- Reset then read: assert rst_n low mid-cycle, release it, read all 32 registers with re1/re2 high -> every rdata = 0x00000000, busy_vec_o = 0.
- Register 0: we0 writes 0xDEADBEEF to address 0 and issue targets address 0 (ZERO_REG = 1) -> rdata1 at address 0 stays 0, busy_vec_o[0] stays 0.
- Dual-write collision: we0 writes 0x11111111 and we1 writes 0x22222222, both to address 5 -> next cycle reg5 = 0x11111111, busy[5] cleared.
- Scoreboard:
  - issue rd = 7 -> busy2_o = 1 for raddr2 = 7 from the next cycle.
  - we1 writes 0xA5A5A5A5 to address 7 -> with bypass: rdata2 = 0xA5A5A5A5 and busy2 = 0 in that same cycle; without bypass: both take effect one cycle later.
- Set/clear race and flush:
  - issue rd = 9 in the same cycle as we0 writes address 9 -> busy[9] = 1 afterwards.
  - Then flush_i = 1 -> busy_vec_o = 0 next cycle, reg9 keeps its written value.
- Reset mid-operation: busy bits 3 and 4 set, reg3 = 0x5 -> pulse rst_n low asynchronously -> busy_vec_o = 0 and reg3 = 0 before the next clk edge.
